activity_time_tracker: RTL and testbench
========================================

// Module: activity_time_tracker
// PURPOSE
//  Parametrised successor to the fixed 64 ppm / 60 s high-activity tracker; runs in the fitness datapath.
//  Samples pulse rate once per 1 s enable tick in a single fast-clock domain.
//  Accumulates total high-activity seconds, credited only after a qualifying streak.
//  Adds a live streak length, a longest-streak record, saturation flags and a synchronous clear.
// PARAMETERS
//  PPM_W    10  pulse-rate input width
//  CNT_W    10  width of hat / run_len / best_run counters
//  THRESH   64  default high-activity threshold (ppm >= THRESH is "high")
//  QUAL_S   60  consecutive high seconds needed before crediting; legal range 1..2^CNT_W-1
// PORTS
//  clk      in   1      system clock
//  reset    in   1      asynchronous, active-low reset
//  sec_tick in   1      1-cycle pulse, once per second; all sampling happens on it
//  ppm      in   PPM_W  current pulse rate, sampled when sec_tick=1
//  thr_sel  in   1      0: use THRESH; 1: use thr_in
//  thr_in   in   PPM_W  runtime threshold
//  clear    in   1      synchronous clear of hat/best_run/flags; state returns to IDLE
//  hat      out  CNT_W  total credited high-activity seconds
//  run_len  out  CNT_W  current consecutive-high streak length in seconds
//  best_run out  CNT_W  longest streak since reset/clear
//  active   out  1      1 while in ACTIVE (streak qualified)
//  hat_sat  out  1      sticky: hat reached all-ones
// BEHAVIOUR
//  Reset (reset=0, async): every output = 0; state = IDLE.
//  hi = (ppm >= thr), where thr = thr_sel ? thr_in : THRESH. All compares and adds are unsigned.
//  Nothing changes on cycles with sec_tick=0. All updates are registered on the tick edge (1-cycle latency).
//  FSM (transitions evaluated only on sec_tick):
//   IDLE:    hi -> run_len=1; go to QUALIFY, or straight to ACTIVE with hat+=1 when QUAL_S==1. !hi -> stay.
//   QUALIFY: hi -> run_len+=1; if the new run_len==QUAL_S: hat+=QUAL_S, go to ACTIVE, else stay.
//            !hi -> run_len=0, go to IDLE. No credit: partial streaks are discarded.
//   ACTIVE:  hi -> hat+=1, run_len+=1. !hi -> run_len=0, go to IDLE.
//  best_run: on the tick edge, best_run = max(best_run, new run_len). This covers unqualified streaks too.
//  Saturation: hat, run_len and best_run clamp at 2^CNT_W-1 and never wrap.
//   A bulk +QUAL_S that would overflow clamps hat to all-ones.
//   hat_sat sets when hat reaches all-ones and holds until clear or reset.
//  clear=1: hat, run_len, best_run and hat_sat go to 0; state goes to IDLE.
//   clear wins over a simultaneous sec_tick, and that tick's sample is discarded.
//  Threshold change mid-streak: takes effect at the next tick; the current streak is not reset.
//  Reset mid-streak: all progress is lost, including any partial QUALIFY count.
//  active = (state==ACTIVE), driven from the state register.
// STRUCTURE
//  Shared package act_pkg:
//   state encoding localparams ST_IDLE=2'd0, ST_QUAL=2'd1, ST_ACTIVE=2'd2 (2'd3 recovers to IDLE)
//   default constants DEF_THRESH=64, DEF_QUAL_S=60
//  Sub-module sat_accum #(W): saturating accumulator
//   inputs: clk, reset, clr, en, inc[W-1:0]; outputs: q, sat
//   instantiated for hat; run_len and best_run use inline clamped logic
//  Top level holds the FSM, threshold mux and best-run compare.
// TESTING
//  1 QUAL_S=60, ppm=80 for 60 ticks -> hat 0 for ticks 1..59, hat=60 and active=1 after tick 60; 5 more ticks -> hat=65.
//  2 ppm=80 for 59 ticks, then ppm=40 -> hat=0, run_len=0, best_run=59, active=0.
//  3 ppm=64 exactly -> counts as high; ppm=63 -> low. thr_sel=1, thr_in=100, ppm=80 -> no streak.
//  4 CNT_W=6, QUAL_S=60, 70 high ticks -> hat clamps at 63, hat_sat=1, no wrap; clear -> all outputs 0.
//  5 clear and sec_tick asserted together in ACTIVE -> outputs 0, state IDLE, that tick not counted.
//  6 reset asserted mid-QUALIFY, between ticks -> outputs 0 immediately, asynchronously; QUALIFY restarts from 1 after release.

Source files
------------

// File: rtl/activity_time_tracker_pkg.sv
// Shared definitions for the activity-time tracker: state encoding and
// default threshold / qualification constants.
package act_pkg;

  // State encoding; the unused code 2'd3 is steered back to IDLE by the FSM.
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_QUAL   = 2'd1;
  localparam logic [1:0] ST_ACTIVE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE   = ST_IDLE,
    S_QUAL   = ST_QUAL,
    S_ACTIVE = ST_ACTIVE
  } state_t;

  // Defaults carried over from the fixed 64 ppm / 60 s tracker.
  localparam int DEF_THRESH = 64;
  localparam int DEF_QUAL_S = 60;

endpackage

// File: rtl/activity_time_tracker_if.sv
// Sample/result bundle between the once-per-second sampler and the tracker.
interface activity_time_tracker_if #(
  parameter int PPM_W = 10,
  parameter int CNT_W = 10
);
  logic             sec_tick;
  logic [PPM_W-1:0] ppm;
  logic             thr_sel;
  logic [PPM_W-1:0] thr_in;
  logic             clear;
  logic [CNT_W-1:0] hat;
  logic [CNT_W-1:0] run_len;
  logic [CNT_W-1:0] best_run;
  logic             active;
  logic             hat_sat;

  // Producer of samples / consumer of results.
  modport master (
    output sec_tick, ppm, thr_sel, thr_in, clear,
    input  hat, run_len, best_run, active, hat_sat
  );

  // The tracker itself.
  modport slave (
    input  sec_tick, ppm, thr_sel, thr_in, clear,
    output hat, run_len, best_run, active, hat_sat
  );
endinterface

// File: rtl/activity_time_tracker_sat_accum.sv
// Saturating accumulator: adds inc when en is high, clamps at all-ones and
// keeps a sticky flag once the all-ones value has been reached.
module sat_accum #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] inc,
  output logic [W-1:0] q,
  output logic         sat
);

  logic [W:0]   sum;
  logic [W-1:0] q_nx;

  // Widened add so a carry out can be detected and clamped rather than wrapped.
  always_comb begin
    sum  = {1'b0, q} + {1'b0, inc};
    q_nx = sum[W] ? {W{1'b1}} : sum[W-1:0];
  end

  // Accumulator and sticky saturation flag; clr has priority over en.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent behaviour.
    if (!reset) begin
      q   <= '0;
      sat <= 1'b0;
    end else if (clr) begin
      q   <= '0;
      sat <= 1'b0;
    end else if (en) begin
      q <= q_nx;
      if (q_nx == {W{1'b1}}) sat <= 1'b1;
    end
  end

endmodule

// File: rtl/activity_time_tracker.sv
// High-activity time tracker: samples pulse rate on each second tick, credits
// high-activity seconds once a streak qualifies, and tracks live/best streaks.
module activity_time_tracker
  import act_pkg::*;
#(
  parameter int PPM_W  = 10,
  parameter int CNT_W  = 10,
  parameter int THRESH = DEF_THRESH,
  parameter int QUAL_S = DEF_QUAL_S
) (
  input logic                     clk,
  input logic                     reset,
  activity_time_tracker_if.slave  bus
);

  localparam logic [PPM_W-1:0] THR_V  = PPM_W'(THRESH);
  localparam logic [CNT_W-1:0] QUAL_V = CNT_W'(QUAL_S);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] MAX    = {CNT_W{1'b1}};

  state_t           state, state_nx;
  logic [CNT_W-1:0] run_q, run_nx, run_inc;
  logic [CNT_W-1:0] best_q, best_nx;
  logic [PPM_W-1:0] thr;
  logic             hi;
  logic             acc_en;
  logic [CNT_W-1:0] acc_inc;
  logic [CNT_W-1:0] hat_q;
  logic             sat_q;

  // Threshold select, high-activity decision and next-state / credit logic.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    state_nx = state;
    run_nx   = run_q;
    acc_en   = 1'b0;
    acc_inc  = '0;
    thr      = bus.thr_sel ? bus.thr_in : THR_V;
    hi       = (bus.ppm >= thr);
    run_inc  = (run_q == MAX) ? MAX : run_q + ONE;

    if (bus.sec_tick) begin
      case (state)
        S_IDLE: begin
          if (hi) begin
            run_nx = ONE;
            if (QUAL_S == 1) begin
              state_nx = S_ACTIVE;
              acc_en   = 1'b1;
              acc_inc  = ONE;
            end else begin
              state_nx = S_QUAL;
            end
          end
        end
        S_QUAL: begin
          if (hi) begin
            run_nx = run_inc;
            if (run_inc == QUAL_V) begin
              // Whole qualifying streak is credited in one bulk add.
              state_nx = S_ACTIVE;
              acc_en   = 1'b1;
              acc_inc  = QUAL_V;
            end
          end else begin
            // Partial streak is discarded without credit.
            run_nx   = '0;
            state_nx = S_IDLE;
          end
        end
        S_ACTIVE: begin
          if (hi) begin
            run_nx  = run_inc;
            acc_en  = 1'b1;
            acc_inc = ONE;
          end else begin
            run_nx   = '0;
            state_nx = S_IDLE;
          end
        end
        default: begin
          run_nx   = '0;
          state_nx = S_IDLE;
        end
      endcase
    end

    best_nx = (run_nx > best_q) ? run_nx : best_q;
  end

  // State, live streak and best-streak registers; clear beats a same-cycle tick.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= S_IDLE;
      run_q  <= '0;
      best_q <= '0;
    end else if (bus.clear) begin
      state  <= S_IDLE;
      run_q  <= '0;
      best_q <= '0;
    end else if (bus.sec_tick) begin
      state  <= state_nx;
      run_q  <= run_nx;
      best_q <= best_nx;
    end
  end

  sat_accum #(.W(CNT_W)) u_hat (
    .clk   (clk),
    .reset (reset),
    .clr   (bus.clear),
    .en    (acc_en),
    .inc   (acc_inc),
    .q     (hat_q),
    .sat   (sat_q)
  );

  assign bus.hat      = hat_q;
  assign bus.hat_sat  = sat_q;
  assign bus.run_len  = run_q;
  assign bus.best_run = best_q;
  assign bus.active   = (state == S_ACTIVE);

endmodule

// File: tb/tb_activity_time_tracker.sv
// Directed bench for activity_time_tracker. Three instances share one stimulus
// stream: default (CNT_W=10, QUAL_S=60), narrow (CNT_W=6) and QUAL_S=1.
module tb_activity_time_tracker;

  logic       clk = 1'b0;
  logic       reset;
  logic       sec_tick;
  logic [9:0] ppm;
  logic       thr_sel;
  logic [9:0] thr_in;
  logic       clear;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  activity_time_tracker_if #(.PPM_W(10), .CNT_W(10)) if_big ();
  activity_time_tracker_if #(.PPM_W(10), .CNT_W(6))  if_small ();
  activity_time_tracker_if #(.PPM_W(10), .CNT_W(10)) if_q1 ();

  assign if_big.sec_tick   = sec_tick;
  assign if_big.ppm        = ppm;
  assign if_big.thr_sel    = thr_sel;
  assign if_big.thr_in     = thr_in;
  assign if_big.clear      = clear;
  assign if_small.sec_tick = sec_tick;
  assign if_small.ppm      = ppm;
  assign if_small.thr_sel  = thr_sel;
  assign if_small.thr_in   = thr_in;
  assign if_small.clear    = clear;
  assign if_q1.sec_tick    = sec_tick;
  assign if_q1.ppm         = ppm;
  assign if_q1.thr_sel     = thr_sel;
  assign if_q1.thr_in      = thr_in;
  assign if_q1.clear       = clear;

  activity_time_tracker u_big (
    .clk   (clk),
    .reset (reset),
    .bus   (if_big)
  );

  activity_time_tracker #(.CNT_W(6), .QUAL_S(60)) u_small (
    .clk   (clk),
    .reset (reset),
    .bus   (if_small)
  );

  activity_time_tracker #(.QUAL_S(1)) u_q1 (
    .clk   (clk),
    .reset (reset),
    .bus   (if_q1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One second tick carrying sample p; returns on the following negedge.
  task automatic tick(input logic [9:0] p);
    @(negedge clk);
    ppm      = p;
    sec_tick = 1'b1;
    @(negedge clk);
    sec_tick = 1'b0;
  endtask

  task automatic ticks(input int n, input logic [9:0] p);
    for (int i = 0; i < n; i++) tick(p);
  endtask

  // Synchronous clear, optionally with a simultaneous high tick.
  task automatic do_clear(input logic with_tick);
    @(negedge clk);
    clear    = 1'b1;
    sec_tick = with_tick;
    ppm      = 10'd80;
    @(negedge clk);
    clear    = 1'b0;
    sec_tick = 1'b0;
  endtask

  initial begin
    reset    = 1'b0;
    sec_tick = 1'b0;
    ppm      = '0;
    thr_sel  = 1'b0;
    thr_in   = '0;
    clear    = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_hat",    if_big.hat, 0);
    check("rst_run",    if_big.run_len, 0);
    check("rst_best",   if_big.best_run, 0);
    check("rst_active", if_big.active, 0);
    check("rst_sat",    if_big.hat_sat, 0);
    check("rst_q1_hat", if_q1.hat, 0);
    @(negedge clk);
    reset = 1'b1;

    // Idle cycles without a tick change nothing
    repeat (3) @(negedge clk);
    ppm = 10'd200;
    repeat (3) @(negedge clk);
    check("notick_run", if_big.run_len, 0);

    // 1: 60-second qualification, then per-second credit
    tick(10'd80);
    check("q1_first_active", if_q1.active, 1);
    check("q1_first_hat",    if_q1.hat, 1);
    for (int i = 2; i <= 59; i++) begin
      tick(10'd80);
      check("t1_hat_pre", if_big.hat, 0);
    end
    check("t1_run59",    if_big.run_len, 59);
    check("t1_active59", if_big.active, 0);
    tick(10'd80);
    check("t1_hat60",    if_big.hat, 60);
    check("t1_active60", if_big.active, 1);
    check("t1_run60",    if_big.run_len, 60);
    ticks(5, 10'd80);
    check("t1_hat65",    if_big.hat, 65);
    check("t1_best65",   if_big.best_run, 65);
    check("t1_q1_hat65", if_q1.hat, 65);
    check("t1_sm_hat",   if_small.hat, 63);
    check("t1_sm_sat",   if_small.hat_sat, 1);
    check("t1_sm_run",   if_small.run_len, 63);
    tick(10'd40);
    check("t1_drop_run",    if_big.run_len, 0);
    check("t1_drop_active", if_big.active, 0);
    check("t1_drop_hat",    if_big.hat, 65);
    check("t1_drop_best",   if_big.best_run, 65);

    // 2: 59-second streak is not credited
    do_clear(1'b0);
    check("clr_hat",  if_big.hat, 0);
    check("clr_best", if_big.best_run, 0);
    ticks(59, 10'd80);
    tick(10'd40);
    check("t2_hat",    if_big.hat, 0);
    check("t2_run",    if_big.run_len, 0);
    check("t2_best",   if_big.best_run, 59);
    check("t2_active", if_big.active, 0);
    check("t2_q1_hat", if_q1.hat, 59);

    // 3: threshold boundaries and runtime threshold
    do_clear(1'b0);
    tick(10'd64);
    check("t3_eq_high", if_big.run_len, 1);
    tick(10'd63);
    check("t3_below",   if_big.run_len, 0);
    check("t3_best",    if_big.best_run, 1);
    thr_sel = 1'b1;
    thr_in  = 10'd100;
    tick(10'd80);
    check("t3_rt_low",  if_big.run_len, 0);
    tick(10'd100);
    check("t3_rt_eq",   if_big.run_len, 1);
    thr_sel = 1'b0;
    tick(10'd70);
    check("t3_switch_keeps", if_big.run_len, 2);
    tick(10'd10);

    // 4: narrow counters clamp, bulk add clamps, clear zeroes everything
    do_clear(1'b0);
    check("t4_clr_sat", if_small.hat_sat, 0);
    ticks(70, 10'd80);
    check("t4_sm_hat",  if_small.hat, 63);
    check("t4_sm_sat",  if_small.hat_sat, 1);
    check("t4_sm_run",  if_small.run_len, 63);
    check("t4_sm_best", if_small.best_run, 63);
    check("t4_big_hat", if_big.hat, 70);
    check("t4_big_sat", if_big.hat_sat, 0);
    do_clear(1'b0);
    check("t4c_hat",    if_small.hat, 0);
    check("t4c_run",    if_small.run_len, 0);
    check("t4c_best",   if_small.best_run, 0);
    check("t4c_active", if_small.active, 0);
    check("t4c_sat",    if_small.hat_sat, 0);
    ticks(60, 10'd80);
    check("t4_sm_hat60", if_small.hat, 60);
    check("t4_sm_nosat", if_small.hat_sat, 0);
    tick(10'd0);
    ticks(60, 10'd80);
    check("t4_bulk_clamp", if_small.hat, 63);
    check("t4_bulk_sat",   if_small.hat_sat, 1);
    check("t4_big_hat120", if_big.hat, 120);

    // 5: clear wins over a simultaneous tick while ACTIVE
    do_clear(1'b0);
    ticks(61, 10'd80);
    check("t5_pre_active", if_big.active, 1);
    check("t5_pre_hat",    if_big.hat, 61);
    do_clear(1'b1);
    check("t5_hat",    if_big.hat, 0);
    check("t5_run",    if_big.run_len, 0);
    check("t5_best",   if_big.best_run, 0);
    check("t5_active", if_big.active, 0);
    check("t5_q1_hat", if_q1.hat, 0);
    tick(10'd80);
    check("t5_restart_run",    if_big.run_len, 1);
    check("t5_restart_active", if_big.active, 0);
    check("t5_q1_restart",     if_q1.hat, 1);

    // 6: async reset in the middle of QUALIFY
    ticks(2, 10'd80);
    check("t6_pre_run", if_big.run_len, 3);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("t6_async_run",  if_big.run_len, 0);
    check("t6_async_best", if_big.best_run, 0);
    check("t6_async_q1",   if_q1.hat, 0);
    @(negedge clk);
    reset = 1'b1;
    tick(10'd80);
    check("t6_restart_run",    if_big.run_len, 1);
    check("t6_restart_active", if_big.active, 0);
    check("t6_restart_hat",    if_big.hat, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
